// File: rtl/rocketcpu_wb_pkg.sv
// Shared definitions for rocketcpu Wishbone bus blocks: state encoding and
// default address/data widths.
package rocketcpu_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/rocketcpu_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus
// cycle out, one response (read data or ack-timeout error) back.
module rocketcpu_wb_initiator
    import rocketcpu_wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_we,
    input  logic [AW-1:0]   i_cmd_adr,
    input  logic [DW-1:0]   i_cmd_dat,
    input  logic [DW/8-1:0] i_cmd_sel,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [DW-1:0]   o_rsp_dat,
    output logic            o_rsp_err,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    output logic            o_wb_we,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    input  logic [DW-1:0]   i_wb_rdt,
    input  logic            i_wb_ack
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    wb_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    adr_d   = i_cmd_adr;
                    dat_d   = i_cmd_dat;
                    sel_d   = i_cmd_sel;
                    we_d    = i_cmd_we;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + CW'(1);
                // Ack takes priority over a timeout landing on the same cycle.
                if (i_wb_ack) begin
                    rsp_dat_d   = we_q ? '0 : i_wb_rdt;
                    rsp_err_d   = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign o_cmd_ready = (state_q == IDLE) && !i_wb_rst;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_dat   = rsp_dat_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;

endmodule
